three_phase_spwm: RTL and testbench

Parametrised three-phase sinusoidal PWM commutator; generational successor to the fixed 10-bit commutation path. Turns an electrical rotor position and an amplitude command into six gate signals (high/low side per phase) with a single time-multiplexed sine ROM, coherent double-buffered duty updates at PWM period boundaries, and programmable dead time. Sits between the velocity loop (amplitude) plus encoder/position logic and the gate-driver pins.

---
 rtl/three_phase_spwm.sv | 166 ++++++++++++++++
 tb/tb_three_phase_spwm.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/three_phase_spwm.sv
// Three-phase sine PWM: one shared sine ROM sequenced in 4-clk rounds, duties double-buffered
// and swapped at the PWM wrap, per-phase dead time, gates armed only at period boundaries.
module three_phase_spwm #(
  parameter int PWM_WIDTH    = 10,
  parameter int POS_WIDTH    = 13,
  parameter int CYCLE_COUNTS = 1170,
  parameter int DEADTIME     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [PWM_WIDTH-1:0] amplitude,
  input  logic [POS_WIDTH-1:0] position,
  output logic [2:0]           gate_hi,
  output logic [2:0]           gate_lo,
  output logic [PWM_WIDTH-1:0] duty_a,
  output logic [PWM_WIDTH-1:0] duty_b,
  output logic [PWM_WIDTH-1:0] duty_c,
  output logic                 period_start
);
  localparam int W   = PWM_WIDTH;
  localparam int AW  = $clog2(CYCLE_COUNTS);
  localparam int DTW = $clog2(DEADTIME + 1);
  localparam int PX  = POS_WIDTH + 1;
  localparam logic [PX-1:0]  CC     = PX'(CYCLE_COUNTS);
  localparam logic [PX-1:0]  T1     = PX'(CYCLE_COUNTS / 3);
  localparam logic [PX-1:0]  T2     = PX'(2 * (CYCLE_COUNTS / 3));
  localparam logic [W-1:0]   HALF   = {1'b1, {(W-1){1'b0}}};
  localparam logic [DTW-1:0] DT_MAX = DTW'(DEADTIME);
  localparam real PI = 3.141592653589793;

  function automatic logic signed [W-1:0] sine_entry(input int k);
    real r;
    int  v;
    r = (2.0 ** (W - 1) - 1.0) * $sin(2.0 * PI * k / CYCLE_COUNTS);
    v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    return W'(v);
  endfunction

  function automatic logic [W-1:0] scale(input logic signed [W-1:0] s, input logic [W-1:0] amp);
    logic signed [2*W:0] prod;
    prod = s * $signed({1'b0, amp});
    return W'(prod >>> W) + HALF;
  endfunction

  typedef enum logic [1:0] {LOOK_A, LOOK_B, LOOK_C, COMMIT} state_t;
  state_t state, state_nxt;

  logic signed [W-1:0] rom [CYCLE_COUNTS];
  for (genvar k = 0; k < CYCLE_COUNTS; k++) begin : g_rom
    assign rom[k] = sine_entry(k);
  end

  logic [POS_WIDTH-1:0] pos_h;
  logic [W-1:0]         amp_h;
  logic [PX-1:0]        p, sum_b, sum_c, idx_b, idx_c, sel;
  logic [AW-1:0]        addr;
  logic signed [W-1:0]  rom_q;
  logic [W-1:0]         scaled_a, scaled_b;
  logic [W-1:0]         shadow [3];
  logic [W-1:0]         duty [3];
  logic [W-1:0]         cnt;
  logic [2:0]           raw, raw_nxt, dt_done;
  logic [DTW-1:0]       dt_cnt [3];
  logic                 armed;

  // Phase B sits 2T ahead in the table (lagging A by 120 deg), C sits T ahead.
  always_comb begin
    p     = ({1'b0, pos_h} >= CC) ? {1'b0, pos_h} - CC : {1'b0, pos_h};
    sum_b = p + T2;
    sum_c = p + T1;
    idx_b = (sum_b >= CC) ? sum_b - CC : sum_b;
    idx_c = (sum_c >= CC) ? sum_c - CC : sum_c;
    sel   = p;
    case (state)
      LOOK_B:  sel = idx_b;
      LOOK_C:  sel = idx_c;
      default: sel = p;
    endcase
    addr = AW'(sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOOK_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOOK_A:  state_nxt = LOOK_B;
      LOOK_B:  state_nxt = LOOK_C;
      LOOK_C:  state_nxt = COMMIT;
      COMMIT:  state_nxt = LOOK_A;
      default: state_nxt = LOOK_A;
    endcase
  end

  // ROM data for a phase arrives one cycle after its LOOK state; phase C is scaled in COMMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_h    <= '0;
      amp_h    <= '0;
      rom_q    <= '0;
      scaled_a <= '0;
      scaled_b <= '0;
      for (int i = 0; i < 3; i++) shadow[i] <= '0;
    end else begin
      rom_q <= rom[addr];
      case (state)
        LOOK_B: scaled_a <= scale(rom_q, amp_h);
        LOOK_C: scaled_b <= scale(rom_q, amp_h);
        COMMIT: begin
          shadow[0] <= scaled_a;
          shadow[1] <= scaled_b;
          shadow[2] <= scale(rom_q, amp_h);
          pos_h     <= position;
          amp_h     <= amplitude;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    raw_nxt = '0;
    dt_done = '0;
    for (int i = 0; i < 3; i++) begin
      raw_nxt[i] = (cnt < duty[i]);
      dt_done[i] = (dt_cnt[i] == DT_MAX);
    end
  end

  // Dead-time counter clears on the same edge raw toggles, so a stale saturated count never leaks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      raw   <= '0;
      armed <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        duty[i]   <= '0;
        dt_cnt[i] <= '0;
      end
    end else begin
      cnt   <= cnt + W'(1);
      raw   <= raw_nxt;
      armed <= enable & (armed | period_start);
      for (int i = 0; i < 3; i++) begin
        if (cnt == '1)
          duty[i] <= shadow[i];
        if (raw_nxt[i] != raw[i])
          dt_cnt[i] <= '0;
        else if (!dt_done[i])
          dt_cnt[i] <= dt_cnt[i] + DTW'(1);
      end
    end
  end

  assign period_start = (cnt == '0);
  assign gate_hi      = {3{armed & enable}} & raw & dt_done;
  assign gate_lo      = {3{armed & enable}} & ~raw & dt_done;
  assign duty_a       = duty[0];
  assign duty_b       = duty[1];
  assign duty_c       = duty[2];

endmodule

// File: tb/tb_three_phase_spwm.sv
// Scoreboard bench: stimulus pushes model duties per applied input; monitor pops at each
// period_start and checks duties plus gate on-times of the window those duties drive.
module tb_three_phase_spwm;
  localparam int W   = 10;
  localparam int PW  = 13;
  localparam int CC  = 1170;
  localparam int DT  = 8;
  localparam int PER = 1024;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [W-1:0]  amplitude;
  logic [PW-1:0] position;
  logic [2:0]    gate_hi, gate_lo;
  logic [W-1:0]  duty_a, duty_b, duty_c;
  logic          period_start;

  three_phase_spwm #(.PWM_WIDTH(W), .POS_WIDTH(PW), .CYCLE_COUNTS(CC), .DEADTIME(DT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .amplitude(amplitude), .position(position),
    .gate_hi(gate_hi), .gate_lo(gate_lo), .duty_a(duty_a), .duty_b(duty_b), .duty_c(duty_c),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d[3];
    int alt[3];
    bit has_alt;
    int lo;
    int amp;
  } exp_t;

  exp_t q[$];
  int   nchk = 0, npass = 0;
  int   last_d[3] = '{512, 512, 512};

  task automatic check(input string name, input bit ok, input int act, input int req);
    nchk++;
    if (ok) npass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference: fold, phase offsets, rounded sine, floor-scaled amplitude, offset by half scale.
  function automatic int ref_duty(input int pos, input int amp, input int ph);
    int  k, s, prod, qv;
    real r;
    k = (pos % CC + (ph == 1 ? 2 * CC / 3 : (ph == 2 ? CC / 3 : 0))) % CC;
    r = 511.0 * $sin(2.0 * 3.141592653589793 * k / CC);
    s = (r >= 0.0) ? $rtoi($floor(r + 0.5)) : -$rtoi($floor(-r + 0.5));
    prod = s * amp;
    qv = (prod >= 0) ? prod / 1024 : -((-prod + 1023) / 1024);
    return (512 + qv) % PER;
  endfunction

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 2 * PER + 50);
    if (!period_start) check("period_start_timeout", 1'b0, n, PER);
  endtask

  task automatic apply(input int pos, input int amp, input int off, input bit late, input int lo);
    exp_t e;
    wait_ps();
    repeat (off) @(posedge clk);
    #1;
    position  = PW'(pos);
    amplitude = W'(amp);
    for (int i = 0; i < 3; i++) begin
      e.d[i]    = ref_duty(pos, amp, i);
      e.alt[i]  = last_d[i];
      last_d[i] = e.d[i];
    end
    e.has_alt = late;
    e.lo      = lo;
    e.amp     = amp;
    q.push_back(e);
  endtask

  int   gh[3], gl[3], cur_d[3], act[3];
  int   cur_lo, ex_hi, overlap_cnt = 0, unstable_cnt = 0;
  bit   have_cur = 0, en_ok = 0, prev_vld = 0, mn, mo;
  logic [3*W-1:0] prev_duty;
  exp_t e_m;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        have_cur = 0;
        prev_vld = 0;
        en_ok    = 0;
      end else begin
        if ((gate_hi & gate_lo) != 3'b000) overlap_cnt++;
        if (prev_vld && !period_start && {duty_a, duty_b, duty_c} != prev_duty) unstable_cnt++;
        prev_duty = {duty_a, duty_b, duty_c};
        prev_vld  = 1;
        if (period_start) begin
          if (have_cur && en_ok) begin
            for (int i = 0; i < 3; i++) begin
              ex_hi = (cur_d[i] > DT) ? cur_d[i] - DT : 0;
              check($sformatf("gate_hi_time[%0d]", i), gh[i] == ex_hi, gh[i], ex_hi);
              if (cur_lo >= 0)
                check($sformatf("gate_lo_time[%0d]", i), gl[i] == cur_lo, gl[i], cur_lo);
            end
          end
          have_cur = 0;
          if (q.size() > 0) begin
            e_m = q.pop_front();
            act[0] = int'(duty_a);
            act[1] = int'(duty_b);
            act[2] = int'(duty_c);
            mn = (act[0] == e_m.d[0]) && (act[1] == e_m.d[1]) && (act[2] == e_m.d[2]);
            mo = e_m.has_alt && (act[0] == e_m.alt[0]) && (act[1] == e_m.alt[1]) && (act[2] == e_m.alt[2]);
            if (!e_m.has_alt) begin
              for (int i = 0; i < 3; i++)
                check($sformatf("duty[%0d]", i), act[i] == e_m.d[i], act[i], e_m.d[i]);
            end else begin
              check("duty_swap_coherent", mn || mo, int'({duty_a, duty_b, duty_c}),
                    (e_m.d[0] << 20) | (e_m.d[1] << 10) | e_m.d[2]);
            end
            if (e_m.amp == PER - 1)
              for (int i = 0; i < 3; i++)
                check($sformatf("duty_range[%0d]", i), act[i] >= 1 && act[i] <= PER - 1, act[i], 1);
            if (mn || mo) begin
              have_cur = 1;
              cur_lo   = e_m.lo;
              for (int i = 0; i < 3; i++) cur_d[i] = mn ? e_m.d[i] : e_m.alt[i];
            end
          end
          for (int i = 0; i < 3; i++) begin
            gh[i] = 0;
            gl[i] = 0;
          end
          en_ok = 1;
        end
        if (!enable) en_ok = 0;
        for (int i = 0; i < 3; i++) begin
          gh[i] += int'(gate_hi[i]);
          gl[i] += int'(gate_lo[i]);
        end
      end
    end
  end

  int bad, n, on, pos_r, amp_r, off_r;

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    amplitude = '0;
    position  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_gates", (gate_hi | gate_lo) == 3'b000, int'({gate_hi, gate_lo}), 0);
    check("reset_duty_a", duty_a == '0, int'(duty_a), 0);
    check("reset_duty_b", duty_b == '0, int'(duty_b), 0);
    check("reset_duty_c", duty_c == '0, int'(duty_c), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("period_start_after_release", period_start == 1'b1, int'(period_start), 1);
    @(negedge clk);
    check("period_start_one_cycle", period_start == 1'b0, int'(period_start), 0);
    bad = 0;
    repeat (PER + 100) begin
      @(negedge clk);
      if ((gate_hi | gate_lo) != 3'b000) bad++;
    end
    check("gates_off_while_disabled", bad == 0, bad, 0);

    enable = 1'b1;
    apply(0, 1023, 1, 0, -1);
    apply(1170, 1023, 1, 0, -1);
    apply(0, 0, 1, 0, -1);
    apply(777, 0, 1, 0, PER - 512 - DT);
    apply(389, 1023, 1, 0, -1);
    apply(390, 1023, 1, 0, -1);
    apply(779, 1023, 1, 0, -1);
    apply(780, 1023, 1, 0, -1);
    apply(1169, 1023, 1, 0, -1);
    apply(2339, 1023, 1, 0, -1);
    for (int i = 0; i < 30; i++) begin
      pos_r = int'($urandom_range(0, 2 * CC - 1));
      amp_r = (i % 3 == 0) ? 1023 : int'($urandom_range(0, 1023));
      off_r = int'($urandom_range(1, 1000));
      apply(pos_r, amp_r, off_r, 0, -1);
    end
    apply(500, 300, 1, 0, -1);
    apply(100, 1023, PER - 2, 1, -1);
    apply(100, 1023, 1, 0, -1);

    wait_ps();
    repeat (300) @(posedge clk);
    #1 enable = 1'b0;
    #1 check("gate_off_same_cycle", (gate_hi | gate_lo) == 3'b000, int'({gate_hi, gate_lo}), 0);
    repeat (300) @(posedge clk);
    #1 enable = 1'b1;
    bad = 0;
    n   = 0;
    do begin
      @(negedge clk);
      if ((gate_hi | gate_lo) != 3'b000) bad++;
      n++;
    end while (!period_start && n < 2 * PER);
    check("gates_held_until_period_start", bad == 0 && period_start, bad, 0);
    on = 0;
    repeat (20) begin
      @(negedge clk);
      if (gate_hi != 3'b000) on++;
    end
    check("gates_resume_after_period_start", on > 0, on, 1);

    wait_ps();
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrun_reset_gates", (gate_hi | gate_lo) == 3'b000, int'({gate_hi, gate_lo}), 0);
    check("midrun_reset_duties", {duty_a, duty_b, duty_c} == '0, int'({duty_a, duty_b, duty_c}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("release_period_start", period_start == 1'b1, int'(period_start), 1);
    check("release_gates_low", (gate_hi | gate_lo) == 3'b000, int'({gate_hi, gate_lo}), 0);
    for (int i = 0; i < 3; i++) last_d[i] = 512;
    apply(0, 1023, 1, 0, -1);
    wait_ps();
    wait_ps();
    repeat (2) @(negedge clk);

    check("scoreboard_drained", q.size() == 0, q.size(), 0);
    check("gate_overlap_cycles", overlap_cnt == 0, overlap_cnt, 0);
    check("duty_change_off_boundary", unstable_cnt == 0, unstable_cnt, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
